// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, one-hot op bit positions, sequencer states.
// Purpose: common types/constants; latency: n/a; backpressure: n/a.
package alu_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_OPW     = 12;
  localparam int ONEHOT_MAXW = 64;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Callers zero-extend narrower op vectors to ONEHOT_MAXW.
  function automatic logic is_onehot(input logic [ONEHOT_MAXW-1:0] op);
    int cnt;
    cnt = 0;
    for (int i = 0; i < ONEHOT_MAXW; i++) cnt += int'(op[i]);
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted req at or after ptr, wrapping; one-hot grant.
// Latency: purely combinational. Backpressure: none, grant follows req/ptr directly.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NREQ requesters, one transaction at a time.
// Latency: accept edge T -> rsp_valid from T+2; one result per 3 cycles at best.
// Backpressure: req_ready only in IDLE; result held in RESP until rsp_ready.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*OPW-1:0]   req_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [OPW-1:0]        alu_op,
  input  logic [WIDTH-1:0]      alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err
);

  state_t                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, id_q, gidx, ptr_nxt;
  logic [WIDTH-1:0]       a_q, b_q, rsp_data_q;
  logic [OPW-1:0]         op_q;
  logic                   err_q;
  logic [NREQ-1:0]        grant;
  logic                   accept;
  logic                   op_ok;
  logic [ONEHOT_MAXW-1:0] op_ext;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gidx = IDW'(i);
    end
  end

  assign ptr_nxt = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
  assign op_ext  = ONEHOT_MAXW'(op_q);
  assign op_ok   = is_onehot(op_ext);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // req_ready is gated by rstn so nothing looks accepted while reset is held.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = rstn ? grant : '0;
        if (|grant) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_op  = op_ok ? op_q : '0;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q      <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= req_a[gidx*WIDTH +: WIDTH];
        b_q   <= req_b[gidx*WIDTH +: WIDTH];
        op_q  <= req_op[gidx*OPW +: OPW];
        id_q  <= gidx;
        ptr_q <= ptr_nxt;
      end
      if (state_q == EXEC) begin
        rsp_data_q <= op_ok ? alu_out : '0;
        err_q      <= !op_ok;
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_id   = id_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a cycle-level reference model and result scoreboard.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int OPW  = 12;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a = '0;
  logic [NREQ*W-1:0]   req_b = '0;
  logic [NREQ*OPW-1:0] req_op = '0;
  logic [W-1:0]        alu_a, alu_b, alu_out;
  logic [OPW-1:0]      alu_op;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [W-1:0]        rsp_data;
  logic                rsp_id;
  logic                rsp_err;

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .OPW(OPW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // External ALU: OR of gated per-op results, so a multi-hot op would blend results.
  always_comb begin
    alu_out = '0;
    if (alu_op[ALU_ADD])  alu_out |= alu_a + alu_b;
    if (alu_op[ALU_SUB])  alu_out |= alu_a - alu_b;
    if (alu_op[ALU_SLT])  alu_out |= {31'b0, $signed(alu_a) < $signed(alu_b)};
    if (alu_op[ALU_SLTU]) alu_out |= {31'b0, alu_a < alu_b};
    if (alu_op[ALU_AND])  alu_out |= alu_a & alu_b;
    if (alu_op[ALU_NOR])  alu_out |= ~(alu_a | alu_b);
    if (alu_op[ALU_OR])   alu_out |= alu_a | alu_b;
    if (alu_op[ALU_XOR])  alu_out |= alu_a ^ alu_b;
    if (alu_op[ALU_SLL])  alu_out |= alu_a << alu_b[4:0];
    if (alu_op[ALU_SRL])  alu_out |= alu_a >> alu_b[4:0];
    if (alu_op[ALU_SRA])  alu_out |= $unsigned($signed(alu_a) >>> alu_b[4:0]);
    if (alu_op[ALU_LUI])  alu_out |= {alu_b[15:0], 16'h0000};
  end

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
    logic [11:0] op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] log_data[$];
  int          log_id[$];
  logic        log_err[$];

  int vectors     = 0;
  int miscompares = 0;
  int m_state     = 0;
  int mptr        = 0;
  int drop_g      = -1;
  bit auto_drop   = 1'b1;

  function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return {31'b0, $signed(a) < $signed(b)};
      12'h008: return {31'b0, a < b};
      12'h010: return a & b;
      12'h020: return ~(a | b);
      12'h040: return a | b;
      12'h080: return a ^ b;
      12'h100: return a << b[4:0];
      12'h200: return a >> b[4:0];
      12'h400: return $unsigned($signed(a) >>> b[4:0]);
      12'h800: return {b[15:0], 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (p + i) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int r, input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[r*OPW +: OPW] = op;
    req_a[r*W +: W]      = a;
    req_b[r*W +: W]      = b;
    req_valid[r]         = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_data"},  rsp_data, 0);
    check({tag, "_rsp_id"},    32'(rsp_id), 0);
    check({tag, "_rsp_err"},   32'(rsp_err), 0);
    check({tag, "_alu_a"},     alu_a, 0);
    check({tag, "_alu_b"},     alu_b, 0);
    check({tag, "_alu_op"},    32'(alu_op), 0);
  endtask

  // One clock: compare against the model at negedge, then advance past posedge.
  task automatic step();
    int              g;
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    @(negedge clk);
    case (m_state)
      0: begin
        g       = rr_pick(req_valid, mptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready_idle", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid_idle", 32'(rsp_valid), 0);
        check("alu_op_idle", 32'(alu_op), 0);
        if (g >= 0) begin
          e.id   = g;
          e.a    = req_a[g*W +: W];
          e.b    = req_b[g*W +: W];
          e.op   = req_op[g*OPW +: OPW];
          e.err  = !$onehot(e.op);
          e.data = e.err ? 32'h0 : ref_alu(e.op, e.a, e.b);
          sbq.push_back(e);
          mptr    = (g + 1) % NREQ;
          m_state = 1;
          drop_g  = g;
        end
      end
      1: begin
        e = sbq[0];
        check("req_ready_exec", 32'(req_ready), 0);
        check("rsp_valid_exec", 32'(rsp_valid), 0);
        check("alu_op_exec", 32'(alu_op), e.err ? 32'h0 : 32'(e.op));
        check("alu_a_exec", alu_a, e.a);
        check("alu_b_exec", alu_b, e.b);
        m_state = 2;
      end
      default: begin
        e = sbq[0];
        check("rsp_valid_resp", 32'(rsp_valid), 1);
        check("req_ready_resp", 32'(req_ready), 0);
        check("rsp_data", rsp_data, e.data);
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        if (rsp_ready) begin
          void'(sbq.pop_front());
          log_data.push_back(rsp_data);
          log_id.push_back(int'(rsp_id));
          log_err.push_back(rsp_err);
          m_state = 0;
        end
      end
    endcase
    @(posedge clk);
    #1;
    // Requester walks away and scribbles its operands once accepted.
    if (auto_drop && drop_g >= 0) begin
      req_valid[drop_g]        = 1'b0;
      req_a[drop_g*W +: W]     = $urandom;
      req_b[drop_g*W +: W]     = $urandom;
      req_op[drop_g*OPW +: OPW] = 12'($urandom);
    end
    drop_g = -1;
  endtask

  task automatic run(input int n, input int budget);
    int start;
    start = log_data.size();
    for (int k = 0; k < budget && (log_data.size() - start) < n; k++) step();
    check("done_count", 32'(log_data.size() - start), 32'(n));
  endtask

  task automatic model_reset();
    sbq.delete();
    m_state = 0;
    mptr    = 0;
    drop_g  = -1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    model_reset();
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;

    // 1: single ADD
    do_reset();
    auto_drop = 1'b1;
    base = log_data.size();
    set_req(0, 12'h001, 32'd2, 32'd1);
    run(1, 20);
    check("t1_data", log_data[base], 32'd3);
    check("t1_id", 32'(log_id[base]), 0);
    check("t1_err", 32'(log_err[base]), 0);

    // 2: both valid, round robin from 0
    do_reset();
    base = log_data.size();
    set_req(0, 12'h002, 32'd2, 32'd1);
    set_req(1, 12'h100, 32'd2, 32'd1);
    run(2, 30);
    check("t2_id0", 32'(log_id[base]), 0);
    check("t2_data0", log_data[base], 32'd1);
    check("t2_id1", 32'(log_id[base+1]), 1);
    check("t2_data1", log_data[base+1], 32'd4);

    // 3: both held valid for four transactions
    do_reset();
    auto_drop = 1'b0;
    base = log_data.size();
    set_req(0, 12'h001, 32'd5, 32'd7);
    set_req(1, 12'h400, 32'h8000_0000, 32'd4);
    run(4, 40);
    req_valid = '0;
    for (int k = 0; k < 4; k++) check("t3_id_seq", 32'(log_id[base+k]), 32'(k % 2));
    check("t3_add", log_data[base], 32'd12);
    check("t3_sra", log_data[base+1], 32'hF800_0000);
    auto_drop = 1'b1;

    // 4: consumer stalls five cycles in RESP
    do_reset();
    base = log_data.size();
    rsp_ready = 1'b0;
    set_req(1, 12'h080, 32'hFF00_FF00, 32'h0FF0_0FF0);
    for (int k = 0; k < 10 && m_state != 2; k++) step();
    check("t4_in_resp", 32'(rsp_valid), 1);
    repeat (5) step();
    rsp_ready = 1'b1;
    step();
    set_req(0, 12'h010, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run(1, 20);
    check("t4_xor", log_data[base], 32'hF0F0_F0F0);
    check("t4_id", 32'(log_id[base]), 1);
    check("t4_and", log_data[base+1], 32'h00F0_1234);

    // 5: zero and multi-hot ops flag an error
    do_reset();
    base = log_data.size();
    set_req(0, 12'h000, 32'd9, 32'd3);
    run(1, 20);
    set_req(0, 12'h003, 32'd9, 32'd3);
    run(1, 20);
    check("t5_err0", 32'(log_err[base]), 1);
    check("t5_data0", log_data[base], 0);
    check("t5_err1", 32'(log_err[base+1]), 1);
    check("t5_data1", log_data[base+1], 0);

    // 6: reset asserted during EXEC, pointer returns to 0
    set_req(0, 12'h001, 32'd1, 32'd1);
    set_req(1, 12'h040, 32'h0000_00F0, 32'h0000_000F);
    step();
    check("t6_pre_grant", 32'(dut.rsp_id), 1);
    #1;
    rstn = 1'b0;
    #1;
    check_all_zero("t6_midreset");
    model_reset();
    base = log_data.size();
    set_req(0, 12'h001, 32'd10, 32'd20);
    set_req(1, 12'h002, 32'd10, 32'd20);
    #1;
    rstn = 1'b1;
    run(1, 20);
    check("t6_id", 32'(log_id[base]), 0);
    check("t6_data", log_data[base], 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
